// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind the UART receiver: frames SYNC/ADDR/LEN/payload/CSUM,
// buffers the payload until the checksum passes, then drains it on a valid/ready stream.
module uart_rx_pkt_ctrl #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned TIMEOUT = 20000,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] out_addr,
  output logic       out_last,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  localparam int unsigned   IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned   TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);
  localparam logic [7:0]    MAXB = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DRAIN
  } state_t;

  state_t        state;
  logic          sync1, sync2, sync3;
  logic          byte_stb;
  logic [7:0]    byte_q;
  logic [7:0]    addr;
  logic [7:0]    len;
  logic [7:0]    idx;
  logic [7:0]    nidx;
  logic [7:0]    csum;
  logic [TW-1:0] tmr;
  logic [7:0]    pbuf [MAX_LEN];

  always_comb nidx = idx + 8'd1;

  // Payload storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == S_DATA && byte_stb) pbuf[idx[IW-1:0]] <= byte_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
      byte_stb  <= 1'b0;
      byte_q    <= '0;
      addr      <= '0;
      len       <= '0;
      idx       <= '0;
      csum      <= '0;
      tmr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= '0;
      drop_cnt  <= '0;
      busy      <= 1'b0;
    end else begin
      sync1    <= rx_ready;
      sync2    <= sync1;
      sync3    <= sync2;
      // Strobe is registered together with the byte, so both are consumed one edge later.
      byte_stb <= sync2 & ~sync3;
      if (sync2 & ~sync3) byte_q <= rx_data;
      pkt_ok  <= 1'b0;
      pkt_err <= 1'b0;

      case (state)
        S_IDLE: begin
          tmr <= '0;
          if (byte_stb && byte_q == SYNC) begin
            state <= S_ADDR;
            busy  <= 1'b1;
          end
        end

        S_ADDR, S_LEN, S_DATA, S_CSUM: begin
          tmr <= '0;
          if (byte_stb) begin
            case (state)
              S_ADDR: begin
                addr  <= byte_q;
                csum  <= byte_q;
                state <= S_LEN;
              end
              S_LEN: begin
                if (byte_q == 8'd0 || byte_q > MAXB) begin
                  pkt_err  <= 1'b1;
                  err_code <= 2'd1;
                  state    <= S_IDLE;
                  busy     <= 1'b0;
                end else begin
                  len   <= byte_q;
                  csum  <= csum ^ byte_q;
                  idx   <= '0;
                  state <= S_DATA;
                end
              end
              S_DATA: begin
                csum <= csum ^ byte_q;
                idx  <= nidx;
                if (idx == len - 8'd1) state <= S_CSUM;
              end
              default: begin
                if (csum == byte_q) begin
                  pkt_ok    <= 1'b1;
                  idx       <= '0;
                  out_valid <= 1'b1;
                  out_data  <= pbuf[0];
                  out_addr  <= addr;
                  out_last  <= (len == 8'd1);
                  state     <= S_DRAIN;
                end else begin
                  pkt_err  <= 1'b1;
                  err_code <= 2'd2;
                  state    <= S_IDLE;
                  busy     <= 1'b0;
                end
              end
            endcase
          end else if (tmr == TLIM) begin
            pkt_err  <= 1'b1;
            err_code <= 2'd3;
            state    <= S_IDLE;
            busy     <= 1'b0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end

        S_DRAIN: begin
          tmr <= '0;
          if (byte_stb && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= S_IDLE;
              busy      <= 1'b0;
            end else begin
              idx      <= nidx;
              out_data <= pbuf[nidx[IW-1:0]];
              out_addr <= out_addr + 8'd1;
              out_last <= (nidx == len - 8'd1);
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl: stimulus pushes expected pulses/beats derived
// from the frame rules, a negedge monitor pops and compares them.
module tb_uart_rx_pkt_ctrl;
  localparam int unsigned MAXL = 16;
  localparam int unsigned TMO  = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_ready = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid, out_last, pkt_ok, pkt_err, busy;
  logic [7:0] out_data, out_addr, drop_cnt;
  logic [1:0] err_code;

  uart_rx_pkt_ctrl #(.MAX_LEN(MAXL), .TIMEOUT(TMO), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .err_code(err_code), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;   // 0 ok pulse, 1 err pulse, 2 beat
    logic [7:0] data;
    logic [7:0] addr;
    logic       last;
    logic [1:0] code;
    int         at;     // required cycle of the pulse, 0 = any
  } exp_t;

  exp_t       q[$];
  logic [7:0] pay[$];
  int         tests = 0;
  int         fails = 0;
  int         vcnt = 0;
  int         last_cons = 0;
  int         exp_drop = 0;
  logic       rdy_hold = 1'b0;
  int         rdy_pct = 100;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic [7:0] a,
                      input logic l, input logic [1:0] c, input int at);
    exp_t e;
    e.kind = k; e.data = d; e.addr = a; e.last = l; e.code = c; e.at = at;
    q.push_back(e);
  endtask

  // Byte appears after posedge c0, so it is consumed at edge c0+4.
  task automatic send_byte(input logic [7:0] b);
    int c0;
    @(posedge clk); #1;
    c0 = cyc;
    rx_data = b;
    rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    last_cons = c0 + 4;
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue_pkt(input logic [7:0] a, input logic [7:0] l, input logic [7:0] cx);
    logic [7:0] cs;
    if (l == 8'd0 || l > MAXL) begin
      push(1, '0, '0, 1'b0, 2'd1, 0);
      send_byte(8'hA5); send_byte(a); send_byte(l);
    end else begin
      cs = a ^ l;
      for (int i = 0; i < int'(l); i++) cs ^= pay[i];
      if (cx == 8'd0) begin
        push(0, '0, '0, 1'b0, 2'd0, 0);
        for (int i = 0; i < int'(l); i++) push(2, pay[i], 8'(a + i), i == int'(l) - 1, 2'd0, 0);
      end else begin
        push(1, '0, '0, 1'b0, 2'd2, 0);
      end
      send_byte(8'hA5); send_byte(a); send_byte(l);
      for (int i = 0; i < int'(l); i++) send_byte(pay[i]);
      send_byte(cs ^ cx);
    end
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy && !out_valid) break;
    end
    chk(nm, {30'd0, q.size() == 0, busy}, 32'd2);
  endtask

  task automatic set_pay3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    pay.delete();
    pay.push_back(a); pay.push_back(b); pay.push_back(c);
  endtask

  initial forever begin
    @(posedge clk); #1;
    out_ready = !rdy_hold && ($urandom_range(99) < rdy_pct);
  end

  // Monitor
  logic       held = 1'b0;
  logic [7:0] pd, pa;
  logic       pl;
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      held = 1'b0;
    end else begin
      if (pkt_ok || pkt_err) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL pulse: unexpected ok=%0b err=%0b code=%0d at cycle %0d", pkt_ok, pkt_err, err_code, cyc);
        end else begin
          e = q.pop_front();
          if ((pkt_ok && pkt_err) || (e.kind == 2) || (pkt_ok != (e.kind == 0)) ||
              (e.kind == 1 && err_code != e.code) || (e.at != 0 && cyc != e.at)) begin
            fails++;
            $display("FAIL pulse: got ok=%0b err=%0b code=%0d cyc=%0d expected kind=%0d code=%0d at=%0d",
                     pkt_ok, pkt_err, err_code, cyc, e.kind, e.code, e.at);
          end
        end
      end
      if (out_valid) begin
        vcnt++;
        tests++;
        if (!busy) begin
          fails++;
          $display("FAIL busy: got 0 expected 1 while out_valid at cycle %0d", cyc);
        end
        if (held) begin
          tests++;
          if ({out_data, out_addr, out_last} !== {pd, pa, pl}) begin
            fails++;
            $display("FAIL stable: got %h/%h/%b expected %h/%h/%b", out_data, out_addr, out_last, pd, pa, pl);
          end
        end
        if (out_ready) begin
          tests++;
          if (q.size() == 0 || q[0].kind != 2) begin
            fails++;
            $display("FAIL beat: unexpected data=%h addr=%h last=%b at cycle %0d", out_data, out_addr, out_last, cyc);
            if (q.size() != 0) void'(q.pop_front());
          end else begin
            e = q.pop_front();
            if ({out_data, out_addr, out_last} !== {e.data, e.addr, e.last}) begin
              fails++;
              $display("FAIL beat: got %h/%h/%b expected %h/%h/%b", out_data, out_addr, out_last, e.data, e.addr, e.last);
            end
          end
        end
        held = !out_ready;
        pd = out_data; pa = out_addr; pl = out_last;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected end", cyc);
    $fatal(1);
  end

  initial begin
    int e0;
    logic [7:0] l, cx;
    repeat (3) @(negedge clk);
    chk("reset_state", {out_valid, out_last, pkt_ok, pkt_err, busy, out_data, out_addr, err_code, drop_cnt}, '0);
    @(posedge clk); #1 rst = 1'b1;

    // good packet at full ready: one beat per cycle
    rdy_pct = 100;
    vcnt = 0;
    set_pay3(8'h11, 8'h22, 8'h33);
    issue_pkt(8'h10, 8'd3, 8'h00);
    wait_done("good_done");
    chk("good_beats", vcnt, 3);

    // bad checksum: A5 10 01 55 00
    pay.delete(); pay.push_back(8'h55);
    issue_pkt(8'h10, 8'd1, 8'h44);
    wait_done("bad_csum_done");
    chk("err_code_hold", err_code, 2);
    issue_pkt(8'h10, 8'd0, 8'h00);
    wait_done("len0_done");
    issue_pkt(8'h10, 8'h11, 8'h00);
    wait_done("len17_done");
    set_pay3(8'h01, 8'h80, 8'h7F);
    pay.push_back(8'hC3);
    issue_pkt(8'h40, 8'd4, 8'h00);
    wait_done("after_err_done");

    // leading junk
    send_byte(8'h00); send_byte(8'hFF);
    set_pay3(8'hAA, 8'hA5, 8'h5A);
    issue_pkt(8'h33, 8'd3, 8'h00);
    wait_done("junk_done");

    // timeout after A5 20
    push(1, '0, '0, 1'b0, 2'd3, 0);
    send_byte(8'hA5); send_byte(8'h20);
    q[q.size()-1].at = last_cons + TMO;
    wait_done("timeout_done");

    // byte landing on the expiry edge is processed
    push(0, '0, '0, 1'b0, 2'd0, 0);
    push(2, 8'h77, 8'h20, 1'b1, 2'd0, 0);
    send_byte(8'hA5); send_byte(8'h20);
    e0 = last_cons;
    wait_until(e0 + TMO - 5);
    send_byte(8'h01);
    send_byte(8'h77);
    send_byte(8'h20 ^ 8'h01 ^ 8'h77);
    wait_done("simul_done");

    // backpressure and drops
    rdy_hold = 1'b1;
    set_pay3(8'h01, 8'h02, 8'h03);
    issue_pkt(8'hFE, 8'd3, 8'h00);
    send_byte(8'h99); send_byte(8'hA5);
    exp_drop += 2;
    @(negedge clk);
    chk("drop2", drop_cnt, exp_drop);
    chk("held_beat", {out_valid, out_data, out_addr}, {1'b1, 8'h01, 8'hFE});
    for (int i = 0; i < 260; i++) begin
      send_byte(8'($urandom));
      if (exp_drop < 255) exp_drop++;
    end
    @(negedge clk);
    chk("drop_sat", drop_cnt, exp_drop);
    rdy_hold = 1'b0;
    wait_done("bp_done");

    // reset during DATA
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_reset", {out_valid, out_last, pkt_ok, pkt_err, busy, out_data, out_addr, err_code, drop_cnt}, '0);
    @(posedge clk); #1 rst = 1'b1;
    exp_drop = 0;
    set_pay3(8'hDE, 8'hAD, 8'hBE);
    issue_pkt(8'h80, 8'd3, 8'h00);
    wait_done("post_reset_done");

    // randomized packets
    for (int n = 0; n < 40; n++) begin
      rdy_pct = $urandom_range(30, 100);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        l = 8'($urandom);
        if (l == 8'hA5) l = 8'h00;
        send_byte(l);
      end
      l = 8'($urandom_range(0, MAXL + 2));
      pay.delete();
      for (int j = 0; j < int'(l); j++) pay.push_back(8'($urandom));
      cx = ($urandom_range(3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      issue_pkt(8'($urandom), l, cx);
      wait_done("rand_done");
    end
    chk("drop_final", drop_cnt, exp_drop);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
